// File: rtl/alu_control_issue.sv
// RV32I decode-to-execute issue stage: decodes ALU_Control and control flags at the
// input and buffers them in a 2-entry elastic queue, so in_ready depends only on registered state.
module alu_control_issue #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   instruction,
    input  logic [ADDRESS_BITS-1:0] in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [5:0]              ALU_Control,
    output logic                    branch_op,
    output logic                    jump_op,
    output logic                    illegal,
    output logic [ADDRESS_BITS-1:0] out_pc,
    output logic [4:0]              out_rd
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign funct3      = instruction[14:12];
    assign funct7      = instruction[31:25];
    assign unused_bits = ^instruction[24:15];

    logic [5:0] dec_alu;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_illegal;

    always_comb begin
        dec_alu     = 6'b000000;
        dec_branch  = 1'b0;
        dec_jump    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'h00 ||
                    (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    dec_alu = {2'b00, funct7[5], funct3};
                else
                    dec_illegal = 1'b1;
            end
            7'b0010011: begin
                // Only the shift encodings constrain funct7; the rest carry immediate bits there.
                if (funct3 == 3'b001 && funct7 != 7'h00)
                    dec_illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
                    dec_illegal = 1'b1;
                else if (funct3 == 3'b101 && funct7 == 7'h20)
                    dec_alu = 6'b001101;
                else
                    dec_alu = {3'b000, funct3};
            end
            7'b1100011: begin
                if (funct3 == 3'b010 || funct3 == 3'b011)
                    dec_illegal = 1'b1;
                else begin
                    dec_alu    = {3'b010, funct3};
                    dec_branch = 1'b1;
                end
            end
            7'b1101111: begin
                dec_alu  = 6'b011111;
                dec_jump = 1'b1;
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    dec_alu  = 6'b011111;
                    dec_jump = 1'b1;
                end else
                    dec_illegal = 1'b1;
            end
            7'b0000011, 7'b0100011, 7'b0110111, 7'b0010111: dec_alu = 6'b000000;
            default: dec_illegal = 1'b1;
        endcase
    end

    logic [5:0]              alu_q     [2];
    logic                    branch_q  [2];
    logic                    jump_q    [2];
    logic                    illegal_q [2];
    logic [ADDRESS_BITS-1:0] pc_q      [2];
    logic [4:0]              rd_q      [2];
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [1:0]              count;
    logic                    push;
    logic                    pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                alu_q[i]     <= 6'b000000;
                branch_q[i]  <= 1'b0;
                jump_q[i]    <= 1'b0;
                illegal_q[i] <= 1'b0;
                pc_q[i]      <= '0;
                rd_q[i]      <= 5'd0;
            end
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                alu_q[wr_ptr]     <= dec_alu;
                branch_q[wr_ptr]  <= dec_branch;
                jump_q[wr_ptr]    <= dec_jump;
                illegal_q[wr_ptr] <= dec_illegal;
                pc_q[wr_ptr]      <= in_pc;
                rd_q[wr_ptr]      <= instruction[11:7];
                wr_ptr            <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push && !pop)
                count <= count + 2'd1;
            else if (pop && !push)
                count <= count - 2'd1;
        end
    end

    // An empty queue presents zeros rather than whatever the slot last held.
    assign ALU_Control = out_valid ? alu_q[rd_ptr]     : 6'b000000;
    assign branch_op   = out_valid ? branch_q[rd_ptr]  : 1'b0;
    assign jump_op     = out_valid ? jump_q[rd_ptr]    : 1'b0;
    assign illegal     = out_valid ? illegal_q[rd_ptr] : 1'b0;
    assign out_pc      = out_valid ? pc_q[rd_ptr]      : '0;
    assign out_rd      = out_valid ? rd_q[rd_ptr]      : 5'd0;

endmodule

// File: tb/tb_alu_control_issue.sv
// Scoreboard bench for alu_control_issue: a reference decode is queued on every accept
// and compared against the head entry on every pop.
module tb_alu_control_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic [19:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  ALU_Control;
    logic        branch_op;
    logic        jump_op;
    logic        illegal;
    logic [19:0] out_pc;
    logic [4:0]  out_rd;

    alu_control_issue #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Control(ALU_Control), .branch_op(branch_op), .jump_op(jump_op),
        .illegal(illegal), .out_pc(out_pc), .out_rd(out_rd)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  alu;
        logic        br;
        logic        jmp;
        logic        ill;
        logic [19:0] pc;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [19:0] pc);
        exp_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e  = '0;
        e.pc = pc;
        e.rd = ins[11:7];
        if (op == 7'h33) begin
            if (f7 == 7'h00) e.alu = {3'b000, f3};
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.alu = {3'b001, f3};
            else e.ill = 1'b1;
        end else if (op == 7'h13) begin
            if (f3 == 3'd1) begin
                if (f7 == 7'h00) e.alu = 6'b000001; else e.ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) e.alu = 6'b000101;
                else if (f7 == 7'h20) e.alu = 6'b001101;
                else e.ill = 1'b1;
            end else e.alu = {3'b000, f3};
        end else if (op == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1'b1;
            else begin e.alu = {3'b010, f3}; e.br = 1'b1; end
        end else if (op == 7'h6F || (op == 7'h67 && f3 == 3'd0)) begin
            e.alu = 6'b011111; e.jmp = 1'b1;
        end else if (op == 7'h03 || op == 7'h23 || op == 7'h37 || op == 7'h17) begin
            e.alu = 6'b000000;
        end else e.ill = 1'b1;
        return e;
    endfunction

    // Handshakes are sampled mid-cycle; inputs only change just after rising edges.
    always @(negedge clock) begin
        exp_t e;
        if (reset || flush) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check_val("unexpected_pop", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check_val("sb_alu", {26'd0, ALU_Control}, {26'd0, e.alu});
                    check_val("sb_flags", {29'd0, branch_op, jump_op, illegal}, {29'd0, e.br, e.jmp, e.ill});
                    check_val("sb_pc", {12'd0, out_pc}, {12'd0, e.pc});
                    check_val("sb_rd", {27'd0, out_rd}, {27'd0, e.rd});
                end
            end
            if (in_valid && in_ready) sb.push_back(model(instruction, in_pc));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        check_val({tag, "_data"}, {ALU_Control, branch_op, jump_op, illegal, out_pc, out_rd}, 32'd0);
    endtask

    task automatic send_one(input logic [31:0] ins, input logic [19:0] pc);
        tick();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = ins;
        in_pc       = pc;
        #1;
        check_val("no_bypass", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check_val("latency", {31'd0, out_valid}, 32'd1);
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h37, 7'h17, 7'h7F};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instruction = 32'd0; in_pc = 20'd0;
        #12;
        check_idle("reset");
        tick();
        reset = 1'b0;

        send_one(32'h40208033, 20'h100);
        check_val("sub_alu", {26'd0, ALU_Control}, 32'b001000);
        check_val("sub_illegal", {31'd0, illegal}, 32'd0);
        send_one(32'h40315093, 20'h104);
        check_val("srai_alu", {26'd0, ALU_Control}, 32'b001101);
        check_val("srai_rd", {27'd0, out_rd}, 32'd1);
        send_one(32'h0020D463, 20'h108);
        check_val("bge_alu", {26'd0, ALU_Control}, 32'b010101);
        check_val("bge_branch", {31'd0, branch_op}, 32'd1);
        send_one(32'h022080B3, 20'h10C);
        check_val("mul_illegal", {31'd0, illegal}, 32'd1);
        check_val("mul_alu", {26'd0, ALU_Control}, 32'd0);
        send_one(32'hFFFFFFFF, 20'h110);
        check_val("ones_illegal", {31'd0, illegal}, 32'd1);
        check_val("ones_alu", {26'd0, ALU_Control}, 32'd0);
        send_one(32'h0000006F, 20'h114);
        check_val("jal_alu", {26'd0, ALU_Control}, 32'b011111);
        check_val("jal_jump", {31'd0, jump_op}, 32'd1);

        // Backpressure: third push must be held until a slot frees.
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h00000013; in_pc = 20'h200;
        tick();
        instruction = 32'h00208133; in_pc = 20'h204;
        tick();
        instruction = 32'h00112023; in_pc = 20'h208;
        check_val("bp_full", {31'd0, in_ready}, 32'd0);
        check_val("bp_head", {12'd0, out_pc}, 32'h200);
        tick();
        check_val("bp_held", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        check_val("bp_ready_again", {31'd0, in_ready}, 32'd1);
        check_val("bp_head2", {12'd0, out_pc}, 32'h204);
        tick();
        in_valid = 1'b0;
        check_val("bp_head3", {12'd0, out_pc}, 32'h208);
        tick();
        check_val("bp_drained", {31'd0, out_valid}, 32'd0);

        // Steady stream with mixed opcodes and random fields.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid    = 1'b1;
            instruction = $urandom;
            instruction[6:0] = ops[$urandom_range(0, 9)];
            in_pc       = 20'h300 + 20'(i * 4);
            tick();
            check_val("stream_in_ready", {31'd0, in_ready}, 32'd1);
            check_val("stream_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check_val("stream_drained", {31'd0, out_valid}, 32'd0);

        // Flush with a full queue and a simultaneous push.
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h00000033; in_pc = 20'h400;
        tick();
        in_pc = 20'h404;
        tick();
        flush = 1'b1; in_pc = 20'h408;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_full");

        // Flush with one entry while a push is accepted: the push must vanish.
        in_valid = 1'b1; in_pc = 20'h40C;
        tick();
        flush = 1'b1; in_pc = 20'h410;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_one");
        send_one(32'h00A00513, 20'h414);
        check_val("after_flush_pc", {12'd0, out_pc}, 32'h414);
        tick();

        // Asynchronous reset with a full queue.
        out_ready = 1'b0;
        in_valid = 1'b1; instruction = 32'h0000006F; in_pc = 20'h500;
        tick();
        in_pc = 20'h504;
        tick();
        in_valid = 1'b0;
        check_val("pre_reset_full", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        #1;
        check_idle("async_reset");
        tick();
        reset = 1'b0;
        send_one(32'h00C0006F, 20'h508);
        check_val("post_reset_pc", {12'd0, out_pc}, 32'h508);
        tick();
        tick();
        check_val("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
